count_step_conditioner: RTL and testbench



---
 rtl/count_step_conditioner.sv | 140 ++++++++++++++
 tb/tb_count_step_conditioner.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_step_conditioner.sv
// count_step_conditioner: turns a raw, bouncing pushbutton into clean
// single-cycle count-enable pulses, with optional auto-repeat while held.
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   btn_in     raw asynchronous pushbutton, active-high
//   repeat_en  1 enables auto-repeat while the button is held
//   step_pulse one-cycle count-enable pulse (registered)
//   btn_level  debounced button level (registered)
//   repeating  high while the auto-repeat FSM is in HOLD_REPEAT (registered)
module count_step_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_PERIOD   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  input  logic repeat_en,
  output logic step_pulse,
  output logic btn_level,
  output logic repeating
);

  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HOLD_DELAY  = 2'd1,
    HOLD_REPEAT = 2'd2
  } state_t;

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] db_cnt;

  state_t           state_q;
  state_t           state_d;
  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_d;
  logic             pulse_d;

  // The debounced level flips on this edge; direction tells press from release.
  logic db_flip;
  logic press;
  logic release_evt;

  assign db_flip     = (sync2 != btn_level) && (db_cnt == DB_LAST);
  assign press       = db_flip && !btn_level;
  assign release_evt = db_flip &&  btn_level;

  // Two-flop synchronizer followed by the integrating debouncer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      if (sync2 == btn_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_level <= sync2;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Auto-repeat FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rpt_cnt    <= '0;
      step_pulse <= 1'b0;
      repeating  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rpt_cnt    <= rpt_d;
      step_pulse <= pulse_d;
      repeating  <= (state_d == HOLD_REPEAT);
    end
  end

  // Next-state logic; a release beats a repeat terminal count on the same edge.
  always_comb begin
    state_d = state_q;
    rpt_d   = rpt_cnt;
    pulse_d = 1'b0;
    if (release_evt) begin
      state_d = IDLE;
      rpt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press) begin
            pulse_d = 1'b1;
            rpt_d   = '0;
            state_d = HOLD_DELAY;
          end
        end
        HOLD_DELAY: begin
          if (!repeat_en) begin
            rpt_d = '0;
          end else if (rpt_cnt == DELAY_LAST) begin
            pulse_d = 1'b1;
            rpt_d   = '0;
            state_d = HOLD_REPEAT;
          end else begin
            rpt_d = rpt_cnt + RPT_W'(1);
          end
        end
        HOLD_REPEAT: begin
          if (!repeat_en) begin
            rpt_d   = '0;
            state_d = HOLD_DELAY;
          end else if (rpt_cnt == PERIOD_LAST) begin
            pulse_d = 1'b1;
            rpt_d   = '0;
          end else begin
            rpt_d = rpt_cnt + RPT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          rpt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_step_conditioner.sv
// Bench for count_step_conditioner: behavioural model compared every cycle,
// plus directed scenarios with hand-derived pulse edge numbers.
module tb_count_step_conditioner;

  localparam int unsigned DEB = 4;
  localparam int unsigned DLY = 8;
  localparam int unsigned PER = 3;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic btn_in    = 1'b0;
  logic repeat_en = 1'b0;
  logic step_pulse;
  logic btn_level;
  logic repeating;

  count_step_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (DLY),
    .REPEAT_PERIOD  (PER)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .repeat_en (repeat_en),
    .step_pulse(step_pulse),
    .btn_level (btn_level),
    .repeating (repeating)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int edge_no     = 0;
  int pulse_edges[$];
  int dut_count   = 0;
  int model_count = 0;

  // Model state: sample pipeline, disagreement run length, hold time since
  // the press (or since repeat_en was last seen low).
  bit m_s1 = 0, m_s2 = 0, m_lvl = 0, m_held = 0, m_pulse = 0, m_rep = 0;
  int m_run = 0;
  int m_t   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, $signed(act), $signed(exp), edge_no);
    end
  endtask

  task automatic model_step();
    bit old_s2, old_lvl;
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0;
      m_held = 0; m_t = 0; m_pulse = 0; m_rep = 0;
    end else begin
      old_s2  = m_s2;
      old_lvl = m_lvl;
      m_pulse = 0;
      if (old_s2 != m_lvl) begin
        m_run++;
        if (m_run == int'(DEB)) begin
          m_lvl = old_s2;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn_in;
      if (!old_lvl && m_lvl) begin
        m_held = 1; m_t = 0; m_pulse = 1;
      end else if (old_lvl && !m_lvl) begin
        m_held = 0; m_t = 0;
      end else if (m_held) begin
        if (!repeat_en) m_t = 0;
        else begin
          m_t++;
          if (m_t == int'(DLY) || (m_t > int'(DLY) && (m_t - int'(DLY)) % int'(PER) == 0))
            m_pulse = 1;
        end
      end
      m_rep = m_held && (m_t >= int'(DLY));
    end
  endtask

  always @(posedge clk or negedge rst_n) model_step();

  always @(posedge clk) edge_no++;

  // Per-cycle comparison against the model, plus pulse logging.
  always @(negedge clk) begin
    check("step_pulse", 32'(step_pulse), 32'(m_pulse));
    check("btn_level",  32'(btn_level),  32'(m_lvl));
    check("repeating",  32'(repeating),  32'(m_rep));
    if (step_pulse === 1'b1) begin
      pulse_edges.push_back(edge_no);
      dut_count++;
    end
    if (m_pulse) model_count++;
  end

  function automatic int pulse_rel(int i, int base);
    if (i < pulse_edges.size()) return pulse_edges[i] - base;
    return -1;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int base;
    int n;

    // Reset state
    rst_n = 1'b0;
    cycles(2);
    check("reset_pulse", 32'(step_pulse), 0);
    check("reset_level", 32'(btn_level), 0);
    check("reset_rep",   32'(repeating), 0);

    // Single press, no repeat: one pulse on edge 6
    rst_n = 1'b1; btn_in = 1'b1; repeat_en = 1'b0;
    base = edge_no;
    pulse_edges.delete();
    cycles(20);
    check("press_count", 32'(pulse_edges.size()), 1);
    check("press_edge",  32'(pulse_rel(0, base)), 6);
    check("press_level", 32'(btn_level), 1);
    btn_in = 1'b0;
    cycles(10);
    check("release_level", 32'(btn_level), 0);
    check("release_nopulse", 32'(pulse_edges.size()), 1);

    // Bounce then stable high
    pulse_edges.delete();
    for (int k = 0; k < 3; k++) begin
      btn_in = 1'b1; cycles(2);
      btn_in = 1'b0; cycles(1);
    end
    btn_in = 1'b1;
    base = edge_no;
    cycles(15);
    check("bounce_count", 32'(pulse_edges.size()), 1);
    check("bounce_edge",  32'(pulse_rel(0, base)), 6);
    btn_in = 1'b0;
    cycles(10);

    // Auto-repeat, release coinciding with a repeat terminal count
    repeat_en = 1'b1;
    pulse_edges.delete();
    btn_in = 1'b1;
    base = edge_no;
    cycles(13);
    check("rep_before", 32'(repeating), 0);
    cycles(1);
    check("rep_after", 32'(repeating), 1);
    cycles(6);
    btn_in = 1'b0;
    cycles(15);
    check("auto_count", 32'(pulse_edges.size()), 5);
    check("auto_p0", 32'(pulse_rel(0, base)), 6);
    check("auto_p1", 32'(pulse_rel(1, base)), 14);
    check("auto_p2", 32'(pulse_rel(2, base)), 17);
    check("auto_p3", 32'(pulse_rel(3, base)), 20);
    check("auto_p4", 32'(pulse_rel(4, base)), 23);
    check("auto_idle_rep", 32'(repeating), 0);
    check("auto_idle_lvl", 32'(btn_level), 0);

    // Next press starts a fresh delay
    pulse_edges.delete();
    btn_in = 1'b1;
    base = edge_no;
    cycles(16);
    check("repress_count", 32'(pulse_edges.size()), 2);
    check("repress_p0", 32'(pulse_rel(0, base)), 6);
    check("repress_p1", 32'(pulse_rel(1, base)), 14);
    btn_in = 1'b0;
    cycles(12);

    // repeat_en low for three edges mid-delay restarts the delay
    pulse_edges.delete();
    btn_in = 1'b1;
    base = edge_no;
    cycles(8);
    repeat_en = 1'b0;
    cycles(3);
    repeat_en = 1'b1;
    cycles(12);
    check("ren_count", 32'(pulse_edges.size()), 3);
    check("ren_p0", 32'(pulse_rel(0, base)), 6);
    check("ren_p1", 32'(pulse_rel(1, base)), 19);
    check("ren_p2", 32'(pulse_rel(2, base)), 22);
    btn_in = 1'b0;
    cycles(12);

    // Asynchronous reset mid-press, button held through release
    btn_in = 1'b1;
    cycles(12);
    check("pre_reset_level", 32'(btn_level), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pulse", 32'(step_pulse), 0);
    check("async_level", 32'(btn_level), 0);
    check("async_rep",   32'(repeating), 0);
    cycles(2);
    pulse_edges.delete();
    rst_n = 1'b1;
    base = edge_no;
    cycles(10);
    check("post_reset_count", 32'(pulse_edges.size()), 1);
    check("post_reset_edge",  32'(pulse_rel(0, base)), 6);
    btn_in = 1'b0;
    cycles(10);

    // Randomized runs against the model
    for (int i = 0; i < 300; i++) begin
      btn_in = ~btn_in;
      n = $urandom_range(1, 14);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 7) == 0) repeat_en = ~repeat_en;
        cycles(1);
      end
      if ($urandom_range(0, 60) == 0) begin
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
      end
    end
    btn_in = 1'b0;
    cycles(12);

    check("downstream_count", 32'(dut_count), 32'(model_count));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
